// File: rtl/divider_restoring_pkg.sv
// rtl/divider_restoring_pkg.sv - shared widths, state encoding and constants for the restoring divider
package divider_restoring_pkg;

    localparam int DVD_W = 16;
    localparam int DVS_W = 8;
    localparam int CNT_W = $clog2(DVD_W + 1);

    // Quotient reported when the divisor is zero
    localparam logic [DVD_W-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_restoring_div_step.sv
// rtl/divider_restoring_div_step.sv - one restoring-division iteration: shift, trial subtract, select
module divider_restoring_div_step
    import divider_restoring_pkg::*;
(
    input  logic [DVS_W:0]   r,
    input  logic [DVD_W-1:0] q,
    input  logic [DVS_W-1:0] d,
    output logic [DVS_W:0]   r_next,
    output logic [DVD_W-1:0] q_next
);

    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] trial;
    logic             borrow;

    // Shift {R,Q} left, subtract the divisor, keep the difference only when it did not borrow
    always_comb begin
        shifted = {r, q[DVD_W-1]};
        trial   = shifted - {2'b00, d};
        borrow  = trial[DVS_W+1];
        if (borrow) begin
            r_next = shifted[DVS_W:0];
            q_next = {q[DVD_W-2:0], 1'b0};
        end else begin
            r_next = trial[DVS_W:0];
            q_next = {q[DVD_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_restoring.sv
// rtl/divider_restoring.sv - sequential restoring divider, one quotient bit per clock
module divider_restoring
    import divider_restoring_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DVD_W-1:0]         dividend,
    input  logic [DVS_W-1:0]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic                     div_by_zero,
    output logic [DVD_W-1:0]         quotient,
    output logic [DVS_W-1:0]         remainder,
    output logic [DVS_W+DVD_W:0]     register
);

    state_t           state;
    state_t           state_next;
    logic [DVS_W:0]   r;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] d;
    logic [CNT_W-1:0] count;
    logic [DVS_W:0]   r_step;
    logic [DVD_W-1:0] q_step;

    divider_restoring_div_step u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_step),
        .q_next (q_step)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a zero divisor skips the iterations and goes straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // Working register, counter and result registers; a captured divisor of zero marks the divide-by-zero path
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= dividend;
                        r     <= '0;
                        d     <= divisor;
                        count <= (divisor == '0) ? '0 : CNT_W'(DVD_W);
                    end
                end
                CALC: begin
                    r     <= r_step;
                    q     <= q_step;
                    count <= count - CNT_W'(1);
                end
                DONE: begin
                    done <= 1'b1;
                    if (d == '0) begin
                        quotient    <= DBZ_QUOTIENT;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q;
                        remainder   <= r[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Debug view of the working register
    always_comb begin
        register = {r, q};
    end

endmodule

// File: tb/tb_divider_restoring.sv
// tb/tb_divider_restoring.sv - directed self-checking bench for divider_restoring
module tb_divider_restoring;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic [24:0] register;

    int total;
    int bad;

    divider_restoring dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .register    (register)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count posedges after the start-sampling edge until done is seen at a negedge; -1 on timeout
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int n);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        wait_done(n);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #20;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%0b want=0", div_by_zero); end
        total++; if (quotient !== 16'd0 || remainder !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d/%0d want=0/0", quotient, remainder); end
        total++; if (register !== 25'd0) begin bad++; $display("FAIL reset_register got=%h want=0", register); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        run_op(16'd45, 8'd5, n);
        total++; if (n !== 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", n); end
        total++; if (quotient !== 16'd9 || remainder !== 8'd0) begin bad++; $display("FAIL basic_45_5 got=%0d r%0d want=9 r0", quotient, remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%0b want=0", div_by_zero); end
        @(posedge clock);
        @(negedge clock);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
        run_op(16'd44000, 8'd220, n);
        total++; if (quotient !== 16'd200 || remainder !== 8'd0) begin bad++; $display("FAIL basic_44000 got=%0d r%0d want=200 r0", quotient, remainder); end
        run_op(16'd44001, 8'd220, n);
        total++; if (quotient !== 16'd200 || remainder !== 8'd1) begin bad++; $display("FAIL basic_44001 got=%0d r%0d want=200 r1", quotient, remainder); end
        total++; if (register !== {9'd1, 16'd200}) begin bad++; $display("FAIL basic_register got=%h want=%h", register, {9'd1, 16'd200}); end
    endtask

    task automatic test_boundaries;
        int n;
        run_op(16'd65535, 8'd1, n);
        total++; if (quotient !== 16'd65535 || remainder !== 8'd0) begin bad++; $display("FAIL bound_div1 got=%0d r%0d want=65535 r0", quotient, remainder); end
        run_op(16'd7, 8'd200, n);
        total++; if (quotient !== 16'd0 || remainder !== 8'd7) begin bad++; $display("FAIL bound_small got=%0d r%0d want=0 r7", quotient, remainder); end
        run_op(16'd65535, 8'd255, n);
        total++; if (quotient !== 16'd257 || remainder !== 8'd0) begin bad++; $display("FAIL bound_max got=%0d r%0d want=257 r0", quotient, remainder); end
        total++; if (n !== 17) begin bad++; $display("FAIL bound_latency got=%0d want=17", n); end
    endtask

    task automatic test_div_by_zero;
        int n;
        run_op(16'd1000, 8'd0, n);
        total++; if (n !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", n); end
        total++; if (quotient !== 16'hFFFF || remainder !== 8'd0) begin bad++; $display("FAIL dbz_result got=%h r%0d want=ffff r0", quotient, remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%0b want=1", div_by_zero); end
        run_op(16'd45, 8'd5, n);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%0b want=0", div_by_zero); end
        total++; if (quotient !== 16'd9) begin bad++; $display("FAIL dbz_next_op got=%0d want=9", quotient); end
    endtask

    task automatic test_ignore_start;
        int n;
        int m;
        @(negedge clock);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%0b want=1", busy); end
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        dividend = 16'd9999;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        m = 0;
        wait_done(m);
        n = (m < 0) ? -1 : m + 5;
        total++; if (n !== 17) begin bad++; $display("FAIL ignore_latency got=%0d want=17", n); end
        total++; if (quotient !== 16'd142 || remainder !== 8'd6) begin bad++; $display("FAIL ignore_result got=%0d r%0d want=142 r6", quotient, remainder); end
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%0b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clock);
        dividend = 16'd45;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n = 0;
        wait_done(n);
        total++; if (n !== 17 || quotient !== 16'd9) begin bad++; $display("FAIL b2b_first got=%0d/q%0d want=17/q9", n, quotient); end
        dividend = 16'd44001;
        divisor  = 8'd220;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%0b want=1", busy); end
        n = 0;
        wait_done(n);
        total++; if (n !== 17) begin bad++; $display("FAIL b2b_latency got=%0d want=17", n); end
        total++; if (quotient !== 16'd200 || remainder !== 8'd1) begin bad++; $display("FAIL b2b_second got=%0d r%0d want=200 r1", quotient, remainder); end
    endtask

    task automatic test_reset_midop;
        int n;
        int seen;
        @(negedge clock);
        dividend = 16'd44000;
        divisor  = 8'd220;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (7) begin
            @(posedge clock);
            @(negedge clock);
        end
        #2;
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=busy%0b done%0b want=busy0 done0", busy, done); end
        total++; if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_result got=%0d r%0d z%0b want=0 r0 z0", quotient, remainder, div_by_zero); end
        total++; if (register !== 25'd0) begin bad++; $display("FAIL midrst_register got=%h want=0", register); end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
        run_op(16'd45, 8'd5, n);
        total++; if (n !== 17 || quotient !== 16'd9 || remainder !== 8'd0) begin bad++; $display("FAIL midrst_recover got=%0d/q%0d r%0d want=17/q9 r0", n, quotient, remainder); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
